// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the shared shift-add multiplier arbiter.
package mul_share_pkg;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned MAX_REQ   = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // First set bit of req at or after ptr, wrapping modulo n; 0 when none is set.
   function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] req,
                                           input int unsigned ptr,
                                           input int unsigned n);
      int unsigned idx;
      logic        found;
      rr_pick = 0;
      found   = 1'b0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         if ((i < n) && !found) begin
            idx = (ptr + i) % n;
            if (req[5'(idx)]) begin
               rr_pick = idx;
               found   = 1'b1;
            end
         end
      end
   endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Sequential LSB-first shift-add multiplier with a fixed WIDTH-cycle latency.
module shift_add_mul
   import mul_share_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   prod,
   output logic                 fin
);

   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH);

   logic [PW-1:0]    a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [CNT_W-1:0] cnt;
   logic             run;

   // The start edge performs iteration 0, so fin rises after WIDTH edges in total.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod <= '0;
         a_sh <= '0;
         b_sh <= '0;
         cnt  <= '0;
         run  <= 1'b0;
         fin  <= 1'b0;
      end else begin
         fin <= 1'b0;
         if (start) begin
            prod <= b[0] ? PW'(a) : '0;
            a_sh <= PW'(a) << 1;
            b_sh <= b >> 1;
            cnt  <= '0;
            run  <= 1'b1;
         end else if (run) begin
            if (b_sh[0]) begin
               prod <= prod + a_sh;
            end
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 2)) begin
               run <= 1'b0;
               fin <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between NUM_REQ requesters.
module mul_share_arbiter
   import mul_share_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   a_in,
   input  logic [NUM_REQ*WIDTH-1:0]   b_in,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       busy,
   output logic                       done,
   output logic [ID_W-1:0]            done_id,
   output logic [WIDTH-1:0]           c,
   output logic                       ovf
);

   state_t              state_q, state_n;
   logic [ID_W-1:0]     ptr_q, ptr_n;
   logic [ID_W-1:0]     id_q, id_n;
   logic [ID_W-1:0]     done_id_n;
   logic [NUM_REQ-1:0]  gnt_n;
   logic                busy_n, done_n, ovf_n;
   logic [WIDTH-1:0]    c_n;
   logic [WIDTH-1:0]    a_sel, b_sel;
   logic [2*WIDTH-1:0]  prod;
   logic                fin;
   logic                start_c;
   int unsigned         pick;

   // Round-robin winner and its operands.
   always_comb begin
      pick  = rr_pick(MAX_REQ'(req), 32'(ptr_q), NUM_REQ);
      a_sel = '0;
      b_sel = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (i == pick) begin
            a_sel = a_in[i*WIDTH +: WIDTH];
            b_sel = b_in[i*WIDTH +: WIDTH];
         end
      end
   end

   assign start_c = (state_q == IDLE) && (|req);

   shift_add_mul #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk   (clk),
      .rst   (rst),
      .start (start_c),
      .a     (a_sel),
      .b     (b_sel),
      .prod  (prod),
      .fin   (fin)
   );

   // Next-state and output logic; result registers hold until the next done.
   always_comb begin
      state_n   = state_q;
      ptr_n     = ptr_q;
      id_n      = id_q;
      gnt_n     = '0;
      done_n    = 1'b0;
      done_id_n = done_id;
      c_n       = c;
      ovf_n     = ovf;
      case (state_q)
         IDLE: begin
            if (start_c) begin
               id_n    = ID_W'(pick);
               ptr_n   = (pick == NUM_REQ - 1) ? '0 : ID_W'(pick + 1);
               gnt_n   = NUM_REQ'(1) << pick;
               state_n = RUN;
            end
         end
         RUN: begin
            if (fin) begin
               c_n       = prod[WIDTH-1:0];
               ovf_n     = |prod[2*WIDTH-1:WIDTH];
               done_n    = 1'b1;
               done_id_n = id_q;
               state_n   = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         gnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= '0;
         c       <= '0;
         ovf     <= 1'b0;
      end else begin
         state_q <= state_n;
         ptr_q   <= ptr_n;
         id_q    <= id_n;
         gnt     <= gnt_n;
         busy    <= busy_n;
         done    <= done_n;
         done_id <= done_id_n;
         c       <= c_n;
         ovf     <= ovf_n;
      end
   end

endmodule
